// File: rtl/hdmi_pkg.sv
// Shared HDMI data-island constants, receive FSM states and the BCH parity step.
package hdmi_pkg;

  localparam logic [7:0] BCH_POLY  = 8'hC1;

  localparam logic [7:0] PKT_ACR   = 8'h01;
  localparam logic [7:0] PKT_AUDIO = 8'h02;
  localparam logic [7:0] PKT_AVI   = 8'h82;
  localparam logic [7:0] PKT_AIF   = 8'h84;

  localparam int PKT_BITS      = 32;
  localparam int HDR_DATA_BITS = 24;
  localparam int SUB_DATA_CYC  = 28;

  typedef enum logic {
    ST_IDLE,
    ST_COLLECT
  } rx_state_e;

  function automatic logic [7:0] bch_step(input logic [7:0] c, input logic b);
    return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? BCH_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/hdmi_bch_check.sv
// BCH parity checker: LFSR over the data bits plus a shift register for received parity.
// ok compares the values *after* this cycle's update, so it is valid on the last parity cycle.
module hdmi_bch_check
  import hdmi_pkg::*;
#(
  parameter int BPC = 1
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           clr,
  input  logic           en_data,
  input  logic           en_par,
  input  logic [BPC-1:0] bits,
  output logic           ok
);

  logic [7:0] lfsr_q, lfsr_d;
  logic [7:0] par_q, par_d;

  // bits[0] is first in time for data and the higher-order bit for parity
  always_comb begin
    lfsr_d = lfsr_q;
    par_d  = par_q;
    if (clr) begin
      lfsr_d = '0;
      par_d  = '0;
    end
    if (en_data) begin
      for (int i = 0; i < BPC; i++) begin
        lfsr_d = bch_step(lfsr_d, bits[i]);
      end
    end
    if (en_par) begin
      for (int i = 0; i < BPC; i++) begin
        par_d = {par_d[6:0], bits[i]};
      end
    end
  end

  assign ok = (lfsr_d == par_d);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lfsr_q <= '0;
      par_q  <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      par_q  <= par_d;
    end
  end

endmodule

// File: rtl/hdmi_data_island_decoder.sv
// Sink-side data-island decoder: reassembles 32-cycle packets after TERC4 decode,
// checks BCH parity, extracts ACR CTS/N and serialises L-PCM audio samples.
module hdmi_data_island_decoder
  import hdmi_pkg::*;
#(
  parameter int CHECK_ECC      = 1,
  parameter int AUDIO_EXTRACT  = 1,
  parameter int DROP_BAD_AUDIO = 1
) (
  input  logic        i_pixclk,
  input  logic        i_resetn,
  input  logic        i_data,
  input  logic [3:0]  i_d0,
  input  logic [3:0]  i_d1,
  input  logic [3:0]  i_d2,
  output logic        o_pkt_valid,
  output logic [23:0] o_hdr,
  output logic [55:0] o_sub0,
  output logic [55:0] o_sub1,
  output logic [55:0] o_sub2,
  output logic [55:0] o_sub3,
  output logic        o_hdr_ok,
  output logic [3:0]  o_sub_ok,
  output logic        o_acr_valid,
  output logic [19:0] o_cts,
  output logic [19:0] o_n,
  output logic        o_aud_valid,
  output logic [15:0] o_audioL,
  output logic [15:0] o_audioR,
  output logic        o_hsync,
  output logic        o_vsync
);

  rx_state_e        state_q, state_d;
  logic [4:0]       off_q, off_d;
  logic [23:0]      hdr_sr_q, hdr_sr_d;
  logic [3:0][55:0] sub_sr_q, sub_sr_d;
  logic [23:0]      hdr_q, hdr_d;
  logic [3:0][55:0] sub_q, sub_d;
  logic             hdr_ok_q, hdr_ok_d;
  logic [3:0]       sub_ok_q, sub_ok_d;
  logic             pkt_valid_q, pkt_valid_d;
  logic             acr_valid_q, acr_valid_d;
  logic [19:0]      cts_q, cts_d, n_q, n_d;
  logic             emit_act_q, emit_act_d;
  logic [1:0]       emit_idx_q, emit_idx_d;
  logic [3:0]       emit_mask_q, emit_mask_d;
  logic             aud_valid_q, aud_valid_d;
  logic [15:0]      aud_l_q, aud_l_d, aud_r_q, aud_r_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d;

  logic       framing_err, pkt_start, pkt_end;
  logic [4:0] cur_off;
  logic       hdr_data_en, hdr_par_en, sub_data_en, sub_par_en;
  logic       hdr_ok_raw, hdr_ok_nx;
  logic [3:0] sub_ok_raw, sub_ok_nx;

  hdmi_bch_check #(.BPC(1)) u_bch_hdr (
    .clk     (i_pixclk),
    .resetn  (i_resetn),
    .clr     (pkt_start),
    .en_data (hdr_data_en),
    .en_par  (hdr_par_en),
    .bits    (i_d0[2]),
    .ok      (hdr_ok_raw)
  );

  for (genvar k = 0; k < 4; k++) begin : g_sub
    hdmi_bch_check #(.BPC(2)) u_bch_sub (
      .clk     (i_pixclk),
      .resetn  (i_resetn),
      .clr     (pkt_start),
      .en_data (sub_data_en),
      .en_par  (sub_par_en),
      .bits    ({i_d2[k], i_d1[k]}),
      .ok      (sub_ok_raw[k])
    );
  end

  assign hdr_ok_nx = (CHECK_ECC != 0) ? hdr_ok_raw : 1'b1;
  assign sub_ok_nx = (CHECK_ECC != 0) ? sub_ok_raw : 4'hF;

  always_comb begin
    // A missing island guard bit mid-packet resynchronises: this cycle becomes offset 0
    framing_err = i_data && (state_q == ST_COLLECT) && (off_q != 5'd0) && !i_d0[3];
    cur_off     = ((state_q == ST_IDLE) || framing_err) ? 5'd0 : off_q;
    pkt_start   = i_data && (cur_off == 5'd0);
    pkt_end     = i_data && (cur_off == 5'(PKT_BITS - 1));
    hdr_data_en = i_data && (cur_off < 5'(HDR_DATA_BITS));
    hdr_par_en  = i_data && !(cur_off < 5'(HDR_DATA_BITS));
    sub_data_en = i_data && (cur_off < 5'(SUB_DATA_CYC));
    sub_par_en  = i_data && !(cur_off < 5'(SUB_DATA_CYC));

    state_d = i_data ? ST_COLLECT : ST_IDLE;
    off_d   = i_data ? cur_off + 5'd1 : 5'd0;

    hdr_sr_d = hdr_sr_q;
    sub_sr_d = sub_sr_q;
    if (hdr_data_en) hdr_sr_d = {i_d0[2], hdr_sr_q[23:1]};
    if (sub_data_en) begin
      for (int k = 0; k < 4; k++) begin
        sub_sr_d[k] = {i_d2[k], i_d1[k], sub_sr_q[k][55:2]};
      end
    end

    hdr_d       = hdr_q;
    sub_d       = sub_q;
    hdr_ok_d    = hdr_ok_q;
    sub_ok_d    = sub_ok_q;
    cts_d       = cts_q;
    n_d         = n_q;
    pkt_valid_d = pkt_end;
    acr_valid_d = 1'b0;
    if (pkt_end) begin
      hdr_d    = hdr_sr_q;
      sub_d    = sub_sr_q;
      hdr_ok_d = hdr_ok_nx;
      sub_ok_d = sub_ok_nx;
      if ((hdr_sr_q[7:0] == PKT_ACR) && sub_ok_nx[0]) begin
        acr_valid_d = 1'b1;
        cts_d = {sub_sr_q[0][11:8], sub_sr_q[0][23:16], sub_sr_q[0][31:24]};
        n_d   = {sub_sr_q[0][35:32], sub_sr_q[0][47:40], sub_sr_q[0][55:48]};
      end
    end

    // Emit scans latched subpackets on the cycles following the packet strobe
    emit_act_d  = emit_act_q;
    emit_idx_d  = emit_idx_q;
    emit_mask_d = emit_mask_q;
    aud_valid_d = 1'b0;
    aud_l_d     = aud_l_q;
    aud_r_d     = aud_r_q;
    if (emit_act_q) begin
      if (emit_mask_q[emit_idx_q]) begin
        aud_valid_d = 1'b1;
        aud_l_d     = sub_q[emit_idx_q][23:8];
        aud_r_d     = sub_q[emit_idx_q][47:32];
      end
      emit_idx_d = emit_idx_q + 2'd1;
      if (emit_idx_q == 2'd3) emit_act_d = 1'b0;
    end
    if (pkt_end && (AUDIO_EXTRACT != 0) && (hdr_sr_q[7:0] == PKT_AUDIO)) begin
      emit_act_d  = 1'b1;
      emit_idx_d  = 2'd0;
      emit_mask_d = hdr_sr_q[11:8] & ((DROP_BAD_AUDIO != 0) ? sub_ok_nx : 4'hF);
    end

    hsync_d = i_data ? i_d0[0] : hsync_q;
    vsync_d = i_data ? i_d0[1] : vsync_q;
  end

  always_ff @(posedge i_pixclk) begin
    if (!i_resetn) begin
      state_q     <= ST_IDLE;
      off_q       <= '0;
      hdr_sr_q    <= '0;
      sub_sr_q    <= '0;
      hdr_q       <= '0;
      sub_q       <= '0;
      hdr_ok_q    <= 1'b0;
      sub_ok_q    <= '0;
      pkt_valid_q <= 1'b0;
      acr_valid_q <= 1'b0;
      cts_q       <= '0;
      n_q         <= '0;
      emit_act_q  <= 1'b0;
      emit_idx_q  <= '0;
      emit_mask_q <= '0;
      aud_valid_q <= 1'b0;
      aud_l_q     <= '0;
      aud_r_q     <= '0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      hdr_sr_q    <= hdr_sr_d;
      sub_sr_q    <= sub_sr_d;
      hdr_q       <= hdr_d;
      sub_q       <= sub_d;
      hdr_ok_q    <= hdr_ok_d;
      sub_ok_q    <= sub_ok_d;
      pkt_valid_q <= pkt_valid_d;
      acr_valid_q <= acr_valid_d;
      cts_q       <= cts_d;
      n_q         <= n_d;
      emit_act_q  <= emit_act_d;
      emit_idx_q  <= emit_idx_d;
      emit_mask_q <= emit_mask_d;
      aud_valid_q <= aud_valid_d;
      aud_l_q     <= aud_l_d;
      aud_r_q     <= aud_r_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
    end
  end

  assign o_pkt_valid = pkt_valid_q;
  assign o_hdr       = hdr_q;
  assign o_sub0      = sub_q[0];
  assign o_sub1      = sub_q[1];
  assign o_sub2      = sub_q[2];
  assign o_sub3      = sub_q[3];
  assign o_hdr_ok    = hdr_ok_q;
  assign o_sub_ok    = sub_ok_q;
  assign o_acr_valid = acr_valid_q;
  assign o_cts       = cts_q;
  assign o_n         = n_q;
  assign o_aud_valid = aud_valid_q;
  assign o_audioL    = aud_l_q;
  assign o_audioR    = aud_r_q;
  assign o_hsync     = hsync_q;
  assign o_vsync     = vsync_q;

endmodule

// File: tb/tb_hdmi_data_island_decoder.sv
// Directed bench for the data-island decoder: packets are serialised onto the nibble lanes
// and decoded fields, ok flags and strobe timing are compared against hand-derived values.
module tb_hdmi_data_island_decoder;

  logic        clk = 1'b0;
  logic        i_resetn, i_data;
  logic [3:0]  i_d0, i_d1, i_d2;
  logic        o_pkt_valid, o_hdr_ok, o_acr_valid, o_aud_valid, o_hsync, o_vsync;
  logic [23:0] o_hdr;
  logic [55:0] o_sub0, o_sub1, o_sub2, o_sub3;
  logic [3:0]  o_sub_ok;
  logic [19:0] o_cts, o_n;
  logic [15:0] o_audioL, o_audioR;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [23:0] p_hdr;
  logic [55:0] p_sub [4];

  int          pv_q [$];
  int          aud_cyc [$];
  logic [15:0] aud_l [$];
  logic [15:0] aud_r [$];
  int          acr_n;

  localparam logic [55:0] AUD_S0 = 56'h00ABCD00123400;
  localparam logic [55:0] AUD_S1 = 56'h00FFFF00000100;
  localparam logic [55:0] AUD_S2 = 56'h00555500777700;
  localparam logic [55:0] ACR_S0 = 56'h00180078690000;
  localparam logic [55:0] AVI_S0 = 56'h00000000191046;

  hdmi_data_island_decoder dut (
    .i_pixclk    (clk),
    .i_resetn    (i_resetn),
    .i_data      (i_data),
    .i_d0        (i_d0),
    .i_d1        (i_d1),
    .i_d2        (i_d2),
    .o_pkt_valid (o_pkt_valid),
    .o_hdr       (o_hdr),
    .o_sub0      (o_sub0),
    .o_sub1      (o_sub1),
    .o_sub2      (o_sub2),
    .o_sub3      (o_sub3),
    .o_hdr_ok    (o_hdr_ok),
    .o_sub_ok    (o_sub_ok),
    .o_acr_valid (o_acr_valid),
    .o_cts       (o_cts),
    .o_n         (o_n),
    .o_aud_valid (o_aud_valid),
    .o_audioL    (o_audioL),
    .o_audioR    (o_audioR),
    .o_hsync     (o_hsync),
    .o_vsync     (o_vsync)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_pkt_valid === 1'b1) pv_q.push_back(cyc);
    if (o_acr_valid === 1'b1) acr_n++;
    if (o_aud_valid === 1'b1) begin
      aud_cyc.push_back(cyc);
      aud_l.push_back(o_audioL);
      aud_r.push_back(o_audioR);
    end
  end

  function automatic logic [7:0] bch_bits(input logic [55:0] v, input int n);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < n; i++) c = {c[6:0], 1'b0} ^ ((c[7] ^ v[i]) ? 8'hC1 : 8'h00);
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_data = 1'b0; i_d0 = 4'h0; i_d1 = 4'h0; i_d2 = 4'h0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_mon();
    pv_q.delete(); aud_cyc.delete(); aud_l.delete(); aud_r.delete();
    acr_n = 0;
  endtask

  task automatic set_pkt(input logic [23:0] h, input logic [55:0] s0, input logic [55:0] s1,
                         input logic [55:0] s2, input logic [55:0] s3);
    p_hdr = h; p_sub[0] = s0; p_sub[1] = s1; p_sub[2] = s2; p_sub[3] = s3;
  endtask

  // Serialises p_hdr/p_sub; drop_at/rst_at/flip_k < 0 disable those disturbances
  task automatic send_pkt(input bit first, input int drop_at, input int rst_at,
                          input int flip_k, input int flip_b);
    logic [7:0]  hp;
    logic [7:0]  sp [4];
    logic [55:0] s  [4];
    int          j;
    hp = bch_bits({32'h0, p_hdr}, 24);
    for (int k = 0; k < 4; k++) begin
      sp[k] = bch_bits(p_sub[k], 56);
      s[k]  = p_sub[k];
    end
    if (flip_k >= 0) s[flip_k][flip_b] = ~s[flip_k][flip_b];
    for (int off = 0; off < 32; off++) begin
      if (off == drop_at) begin
        idle(1);
        return;
      end
      i_data  = 1'b1;
      i_d0[0] = 1'b1;
      i_d0[1] = 1'b0;
      i_d0[3] = !(first && off == 0);
      i_d0[2] = (off < 24) ? p_hdr[off] : hp[31-off];
      for (int k = 0; k < 4; k++) begin
        if (off < 28) begin
          i_d1[k] = s[k][2*off];
          i_d2[k] = s[k][2*off+1];
        end else begin
          j = off - 28;
          i_d1[k] = sp[k][7-2*j];
          i_d2[k] = sp[k][6-2*j];
        end
      end
      if (off == rst_at) i_resetn = 1'b0;
      step();
      if (off == rst_at) begin
        i_resetn = 1'b1;
        i_data   = 1'b0;
        return;
      end
    end
  endtask

  task automatic test_reset();
    i_resetn = 1'b0; i_data = 1'b0; i_d0 = 4'h0; i_d1 = 4'h0; i_d2 = 4'h0;
    repeat (3) step();
    total++;
    if (o_pkt_valid !== 1'b0 || o_acr_valid !== 1'b0 || o_aud_valid !== 1'b0) begin
      bad++; $display("FAIL reset_strobes got %b%b%b want 000", o_pkt_valid, o_acr_valid, o_aud_valid);
    end
    total++;
    if (o_hdr !== 24'h0 || o_sub0 !== 56'h0 || o_sub3 !== 56'h0) begin
      bad++; $display("FAIL reset_data got hdr=%h sub0=%h sub3=%h want 0", o_hdr, o_sub0, o_sub3);
    end
    total++;
    if (o_hdr_ok !== 1'b0 || o_sub_ok !== 4'h0 || o_cts !== 20'h0 || o_n !== 20'h0) begin
      bad++; $display("FAIL reset_flags got hok=%b sok=%h cts=%h n=%h want 0", o_hdr_ok, o_sub_ok, o_cts, o_n);
    end
    total++;
    if (o_audioL !== 16'h0 || o_audioR !== 16'h0 || o_hsync !== 1'b0 || o_vsync !== 1'b0) begin
      bad++; $display("FAIL reset_aud got L=%h R=%h hs=%b vs=%b want 0", o_audioL, o_audioR, o_hsync, o_vsync);
    end
    i_resetn = 1'b1;
    idle(2);
  endtask

  task automatic test_avi();
    int start;
    clear_mon();
    set_pkt(24'h0D0282, AVI_S0, 56'h0, 56'h0, 56'h0);
    start = cyc;
    send_pkt(1'b1, -1, -1, -1, 0);
    idle(6);
    total++;
    if (pv_q.size() != 1 || pv_q[0] != start + 32) begin
      bad++; $display("FAIL avi_strobe got n=%0d first=%0d want 1 at %0d", pv_q.size(),
                      (pv_q.size() > 0) ? pv_q[0] : -1, start + 32);
    end
    total++;
    if (o_hdr !== 24'h0D0282 || o_sub0 !== AVI_S0 || o_sub1 !== 56'h0) begin
      bad++; $display("FAIL avi_data got hdr=%h sub0=%h sub1=%h want 0d0282/%h/0", o_hdr, o_sub0, o_sub1, AVI_S0);
    end
    total++;
    if (o_hdr_ok !== 1'b1 || o_sub_ok !== 4'hF) begin
      bad++; $display("FAIL avi_ok got hok=%b sok=%h want 1/f", o_hdr_ok, o_sub_ok);
    end
    total++;
    if (acr_n != 0 || aud_cyc.size() != 0) begin
      bad++; $display("FAIL avi_no_extract got acr=%0d aud=%0d want 0/0", acr_n, aud_cyc.size());
    end
    total++;
    if (o_hsync !== 1'b1 || o_vsync !== 1'b0) begin
      bad++; $display("FAIL avi_sync got hs=%b vs=%b want 1/0", o_hsync, o_vsync);
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    set_pkt(24'h000001, ACR_S0, 56'h0, 56'h0, 56'h0);
    send_pkt(1'b1, -1, -1, -1, 0);
    set_pkt(24'h000302, AUD_S0, AUD_S1, AUD_S2, AUD_S2);
    send_pkt(1'b0, -1, -1, -1, 0);
    idle(6);
    total++;
    if (acr_n != 1 || o_cts !== 20'd27000 || o_n !== 20'd6144) begin
      bad++; $display("FAIL acr_values got cnt=%0d cts=%0d n=%0d want 1/27000/6144", acr_n, o_cts, o_n);
    end
    total++;
    if (pv_q.size() != 2 || pv_q[1] - pv_q[0] != 32) begin
      bad++; $display("FAIL b2b_spacing got n=%0d want 2 strobes 32 apart", pv_q.size());
    end
    total++;
    if (aud_cyc.size() != 2) begin
      bad++; $display("FAIL b2b_audio got %0d samples want 2", aud_cyc.size());
    end
  endtask

  task automatic test_audio();
    clear_mon();
    set_pkt(24'h000302, AUD_S0, AUD_S1, AUD_S2, AUD_S2);
    send_pkt(1'b1, -1, -1, -1, 0);
    idle(8);
    total++;
    if (pv_q.size() != 1 || aud_cyc.size() != 2) begin
      bad++; $display("FAIL aud_count got pv=%0d aud=%0d want 1/2", pv_q.size(), aud_cyc.size());
    end else begin
      total++;
      if (aud_cyc[0] != pv_q[0] + 1 || aud_cyc[1] != pv_q[0] + 2) begin
        bad++; $display("FAIL aud_timing got +%0d/+%0d want +1/+2", aud_cyc[0] - pv_q[0], aud_cyc[1] - pv_q[0]);
      end
      total++;
      if (aud_l[0] !== 16'h1234 || aud_r[0] !== 16'hABCD) begin
        bad++; $display("FAIL aud_s0 got %h/%h want 1234/abcd", aud_l[0], aud_r[0]);
      end
      total++;
      if (aud_l[1] !== 16'h0001 || aud_r[1] !== 16'hFFFF) begin
        bad++; $display("FAIL aud_s1 got %h/%h want 0001/ffff", aud_l[1], aud_r[1]);
      end
    end
    total++;
    if (acr_n != 0 || o_cts !== 20'd27000) begin
      bad++; $display("FAIL acr_hold got cnt=%0d cts=%0d want 0/27000", acr_n, o_cts);
    end
  endtask

  task automatic test_bad_ecc();
    clear_mon();
    set_pkt(24'h000302, AUD_S0, AUD_S1, AUD_S2, AUD_S2);
    send_pkt(1'b1, -1, -1, 1, 30);
    idle(8);
    total++;
    if (o_sub_ok !== 4'b1101 || o_hdr_ok !== 1'b1) begin
      bad++; $display("FAIL ecc_flags got sok=%b hok=%b want 1101/1", o_sub_ok, o_hdr_ok);
    end
    total++;
    if (aud_cyc.size() != 1) begin
      bad++; $display("FAIL ecc_drop got %0d samples want 1", aud_cyc.size());
    end else begin
      total++;
      if (aud_l[0] !== 16'h1234 || aud_r[0] !== 16'hABCD || aud_cyc[0] != pv_q[0] + 1) begin
        bad++; $display("FAIL ecc_sample got %h/%h at +%0d want 1234/abcd at +1", aud_l[0], aud_r[0], aud_cyc[0] - pv_q[0]);
      end
    end
  endtask

  task automatic test_data_drop();
    int start;
    clear_mon();
    set_pkt(24'h000302, AUD_S0, AUD_S1, AUD_S2, AUD_S2);
    send_pkt(1'b1, 10, -1, -1, 0);
    idle(3);
    set_pkt(24'h0D0282, AVI_S0, 56'h0, 56'h0, 56'h0);
    start = cyc;
    send_pkt(1'b1, -1, -1, -1, 0);
    idle(6);
    total++;
    if (pv_q.size() != 1 || pv_q[0] != start + 32) begin
      bad++; $display("FAIL drop_strobe got n=%0d want 1 at %0d", pv_q.size(), start + 32);
    end
    total++;
    if (o_hdr !== 24'h0D0282 || o_sub0 !== AVI_S0 || o_hdr_ok !== 1'b1 || o_sub_ok !== 4'hF) begin
      bad++; $display("FAIL drop_recover got hdr=%h hok=%b sok=%h want 0d0282/1/f", o_hdr, o_hdr_ok, o_sub_ok);
    end
    total++;
    if (aud_cyc.size() != 0) begin
      bad++; $display("FAIL drop_audio got %0d samples want 0", aud_cyc.size());
    end
  endtask

  task automatic test_mid_reset();
    clear_mon();
    set_pkt(24'h000302, AUD_S0, AUD_S1, AUD_S2, AUD_S2);
    send_pkt(1'b1, -1, 20, -1, 0);
    total++;
    if (o_hdr !== 24'h0 || o_sub_ok !== 4'h0 || o_cts !== 20'h0 || o_hsync !== 1'b0 || o_sub0 !== 56'h0) begin
      bad++; $display("FAIL midrst_zero got hdr=%h sok=%h cts=%h hs=%b want 0", o_hdr, o_sub_ok, o_cts, o_hsync);
    end
    idle(3);
    set_pkt(24'h000001, ACR_S0, 56'h0, 56'h0, 56'h0);
    send_pkt(1'b1, -1, -1, -1, 0);
    idle(4);
    total++;
    if (pv_q.size() != 1 || acr_n != 1 || o_cts !== 20'd27000 || o_n !== 20'd6144 || o_hdr_ok !== 1'b1) begin
      bad++; $display("FAIL midrst_recover got pv=%0d acr=%0d cts=%0d n=%0d want 1/1/27000/6144",
                      pv_q.size(), acr_n, o_cts, o_n);
    end
  endtask

  task automatic test_emit_abort();
    clear_mon();
    set_pkt(24'h000302, AUD_S0, AUD_S1, AUD_S2, AUD_S2);
    send_pkt(1'b1, -1, -1, -1, 0);
    i_data = 1'b0;
    i_resetn = 1'b0;
    step();
    i_resetn = 1'b1;
    idle(6);
    total++;
    if (pv_q.size() != 1 || aud_cyc.size() != 0) begin
      bad++; $display("FAIL emit_abort got pv=%0d aud=%0d want 1/0", pv_q.size(), aud_cyc.size());
    end
  endtask

  initial begin
    acr_n = 0;
    test_reset();
    test_avi();
    test_back_to_back();
    test_audio();
    test_bad_ecc();
    test_data_drop();
    test_mid_reset();
    test_emit_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
